logic_demo_selftest: RTL and testbench

- Sequencer and self-checker for the 4-in/4-out combinational logic demo datapath on the DE1-SoC.
- In test mode it drives all 16 input vectors into the datapath in order, waits a settle time for each, samples the outputs and compares them against an internal golden model.
- It reports a mismatch count, the first failing vector and overall pass/fail.
- In manual mode it forwards the board switches straight to the datapath.

---
 rtl/logic_demo_selftest.sv | 127 ++++++++++++
 tb/tb_logic_demo_selftest.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_demo_selftest.sv
// Self-test sequencer for the 4-in/4-out logic demo datapath: walks all 16 input
// vectors, compares each settled output against a golden model and reports the result.
module logic_demo_selftest #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       mode_manual,
    input  logic [3:0] sw_in,
    output logic [3:0] dut_in,
    input  logic [3:0] dut_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_vec,
    output logic [3:0] first_fail_got
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DRIVE  = 3'd1;
    localparam logic [2:0] SETTLE = 3'd2;
    localparam logic [2:0] SAMPLE = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [2:0] state;
    logic [3:0] vec;
    logic [3:0] settle_cnt;
    logic       start_ok;

    function automatic logic [3:0] golden(input logic [3:0] v);
        return {v[3], ~(v[2] ^ v[0]), v[2] | ~v[1], v[0] & v[1]};
    endfunction

    // Abort takes priority over a coincident start.
    assign start_ok = start & ~abort;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            vec            <= 4'd0;
            settle_cnt     <= 4'd0;
            dut_in         <= 4'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= 5'd0;
            first_fail_vec <= 4'd0;
            first_fail_got <= 4'd0;
        end else if (abort && state != IDLE) begin
            // Partial error results are kept so a cancelled run can still be inspected.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mode_manual) begin
                        dut_in <= sw_in;
                    end
                    if (start_ok) begin
                        state          <= DRIVE;
                        vec            <= 4'd0;
                        err_count      <= 5'd0;
                        first_fail_vec <= 4'd0;
                        first_fail_got <= 4'd0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                    end
                end
                DRIVE: begin
                    dut_in     <= vec;
                    settle_cnt <= SETTLE_LOAD;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == 4'd0) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    if (dut_out != golden(vec)) begin
                        err_count <= err_count + 5'd1;
                        if (err_count == 5'd0) begin
                            first_fail_vec <= vec;
                            first_fail_got <= dut_out;
                        end
                    end
                    if (vec == 4'd15) begin
                        state <= DONE;
                    end else begin
                        vec   <= vec + 4'd1;
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_count == 5'd0);
                    if (start_ok) begin
                        state          <= DRIVE;
                        vec            <= 4'd0;
                        err_count      <= 5'd0;
                        first_fail_vec <= 4'd0;
                        first_fail_got <= 4'd0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_demo_selftest.sv
// Directed bench for logic_demo_selftest: datapath models (correct, stuck bit, delayed)
// driving two sequencer instances with different settle times.
module tb_logic_demo_selftest;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       mode_manual = 1'b0;
    logic [3:0] sw_in = 4'd0;
    logic [3:0] dut_in;
    logic [3:0] dut_out;
    logic       busy, done, pass;
    logic [4:0] err_count;
    logic [3:0] first_fail_vec, first_fail_got;

    logic       start5 = 1'b0;
    logic       abort5 = 1'b0;
    logic [3:0] dut_in5, dut_out5;
    logic       busy5, done5, pass5;
    logic [4:0] err5;
    logic [3:0] ffv5, ffg5;

    int         model_sel = 0;   // 0 correct, 1 out[1] stuck at 0, 2 four-cycle delay
    logic [3:0] pipe [4];
    logic [3:0] pipe5 [4];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] vec;
        logic [3:0] exp_out;
        logic       stuck_miss;
    } vec_t;
    vec_t tbl [16];

    always #5 clk = ~clk;

    logic_demo_selftest #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .mode_manual(mode_manual), .sw_in(sw_in), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_vec(first_fail_vec), .first_fail_got(first_fail_got)
    );

    logic_demo_selftest #(.SETTLE_CYCLES(5)) dut5 (
        .clk(clk), .reset_n(reset_n), .start(start5), .abort(abort5),
        .mode_manual(1'b0), .sw_in(4'd0), .dut_in(dut_in5), .dut_out(dut_out5),
        .busy(busy5), .done(done5), .pass(pass5), .err_count(err5),
        .first_fail_vec(ffv5), .first_fail_got(ffg5)
    );

    // Behavioural datapath under test.
    function automatic logic [3:0] datapath(input logic [3:0] v);
        logic [3:0] r;
        r[0] = v[0] & v[1];
        r[1] = v[2] | ~v[1];
        r[2] = ~(v[2] ^ v[0]);
        r[3] = v[3];
        return r;
    endfunction

    always @(posedge clk) begin
        pipe[0]  <= datapath(dut_in);
        pipe[1]  <= pipe[0];
        pipe[2]  <= pipe[1];
        pipe[3]  <= pipe[2];
        pipe5[0] <= datapath(dut_in5);
        pipe5[1] <= pipe5[0];
        pipe5[2] <= pipe5[1];
        pipe5[3] <= pipe5[2];
    end

    always_comb begin
        dut_out = datapath(dut_in);
        if (model_sel == 1) dut_out = datapath(dut_in) & 4'b1101;
        else if (model_sel == 2) dut_out = pipe[3];
    end
    assign dut_out5 = pipe5[3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    // Pulse start, then follow the run until done (bounded), checking the vector walk.
    task automatic run(input bit chk_seq, input bit spam, input bit toggle_sw, output int cycles);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_clears_err", err_count, 0);
        chk("start_sets_busy", {busy, done, pass}, 3'b100);
        cycles = 0;
        while (done !== 1'b1 && cycles < 300) begin
            start = (spam && cycles < 50 && (cycles % 7) == 3);
            if (toggle_sw) sw_in = 4'($urandom);
            tick();
            cycles++;
            if (chk_seq && (cycles % 4) == 1 && cycles <= 61) begin
                chk($sformatf("seq_dut_in[%0d]", cycles / 4), dut_in, tbl[cycles / 4].vec);
                if (model_sel == 0)
                    chk($sformatf("seq_dut_out[%0d]", cycles / 4), dut_out, tbl[cycles / 4].exp_out);
            end
        end
        start = 1'b0;
        chk("run_length", cycles, 65);
        chk("busy_after_run", busy, 0);
    endtask

    initial begin
        int cyc;
        int exp_err;

        tbl[0]  = '{4'd0,  4'b0110, 1'b1};
        tbl[1]  = '{4'd1,  4'b0010, 1'b1};
        tbl[2]  = '{4'd2,  4'b0100, 1'b0};
        tbl[3]  = '{4'd3,  4'b0001, 1'b0};
        tbl[4]  = '{4'd4,  4'b0010, 1'b1};
        tbl[5]  = '{4'd5,  4'b0110, 1'b1};
        tbl[6]  = '{4'd6,  4'b0010, 1'b1};
        tbl[7]  = '{4'd7,  4'b0111, 1'b1};
        tbl[8]  = '{4'd8,  4'b1110, 1'b1};
        tbl[9]  = '{4'd9,  4'b1010, 1'b1};
        tbl[10] = '{4'd10, 4'b1100, 1'b0};
        tbl[11] = '{4'd11, 4'b1001, 1'b0};
        tbl[12] = '{4'd12, 4'b1010, 1'b1};
        tbl[13] = '{4'd13, 4'b1110, 1'b1};
        tbl[14] = '{4'd14, 4'b1010, 1'b1};
        tbl[15] = '{4'd15, 4'b1111, 1'b1};
        exp_err = 0;
        for (int i = 0; i < 16; i++) exp_err += int'(tbl[i].stuck_miss);

        // Reset state
        #3;
        chk("reset_outputs", {dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_got}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("idle_after_reset", {dut_in, busy, done}, 0);

        // Manual pass-through, table driven
        mode_manual = 1'b1;
        sw_in = 4'b1010;
        tick();
        chk("manual_1010", dut_in, 4'b1010);
        for (int i = 0; i < 16; i++) begin
            sw_in = tbl[i].vec;
            tick();
            chk($sformatf("manual_in[%0d]", i), dut_in, tbl[i].vec);
            chk($sformatf("manual_out[%0d]", i), dut_out, tbl[i].exp_out);
        end
        mode_manual = 1'b0;

        // Correct datapath, full run
        model_sel = 0;
        run(1'b1, 1'b0, 1'b0, cyc);
        chk("good_result", {done, pass, err_count, first_fail_vec, first_fail_got}, {2'b11, 5'd0, 8'd0});

        // Restart from DONE in manual mode with switches toggling
        mode_manual = 1'b1;
        run(1'b1, 1'b0, 1'b1, cyc);
        tick();
        chk("done_holds_dut_in", dut_in, 4'd15);
        chk("manual_good_pass", pass, 1);
        mode_manual = 1'b0;

        // out[1] stuck at 0
        model_sel = 1;
        run(1'b0, 1'b0, 1'b0, cyc);
        chk("stuck_err_count", err_count, exp_err);
        chk("stuck_first_fail", {first_fail_vec, first_fail_got}, {4'd0, 4'b0100});
        chk("stuck_done_pass", {done, pass}, 2'b10);

        // Abort (with coincident start) right after the vector 6 sample
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (28) tick();
        chk("busy_before_abort", busy, 1);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_state", {busy, done, pass}, 3'b000);
        chk("abort_partial_err", err_count, 5);
        chk("abort_partial_ff", {first_fail_vec, first_fail_got}, {4'd0, 4'b0100});
        chk("abort_dut_in_hold", dut_in, 4'd6);
        tick();
        chk("abort_stays_idle", busy, 0);
        model_sel = 0;
        run(1'b0, 1'b0, 1'b0, cyc);
        chk("after_abort_pass", {done, pass, err_count}, {2'b11, 5'd0});

        // Start pulses while busy are ignored
        run(1'b0, 1'b1, 1'b0, cyc);
        chk("spam_pass", {done, pass}, 2'b11);

        // Asynchronous reset mid-run
        model_sel = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        chk("pre_reset_err", err_count, 5);
        reset_n = 1'b0;
        #1;
        chk("async_reset_clears",
            {dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_got}, 0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("no_resume", {busy, done, dut_in}, 0);

        // Slow datapath, short settle: must report failure
        model_sel = 2;
        run(1'b0, 1'b0, 1'b0, cyc);
        chk("slow_short_settle_pass", {done, pass}, 2'b10);

        // Slow datapath, long settle
        start5 = 1'b1;
        tick();
        start5 = 1'b0;
        cyc = 0;
        while (done5 !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        chk("slow_long_settle_len", cyc, 113);
        chk("slow_long_settle_pass", {busy5, done5, pass5, err5}, {3'b011, 5'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
